schnorr_seq_ctrl: RTL and testbench
===================================

// Module: schnorr_seq_ctrl
// PURPOSE
//  Command sequencer for the Schnorr datapath (key_gen / sign_gen / sign_ver).
//  - Accepts one operation at a time: KEYGEN, SIGN or VERIFY.
//  - Drives the en_key / en_gen / en_ver enables and supplies msg_gen / msg_ver.
//  - Waits for the matching valid/done flag, enforces a timeout, latches results and returns one status response.
//  - Sits between the host/bus interface and the schnorr top level.
// PARAMETERS
//  len          16    width of key/signature words (matches datapath len)
//  TIMEOUT_CYC  4096  max cycles an op may stay enabled before abort; >=2
// PORTS
//  clk           in   1    system clock
//  rst           in   1    synchronous, active-high reset
//  cmd_valid     in   1    command present
//  cmd_ready     out  1    controller can accept a command (high only in IDLE)
//  cmd_op        in   2    01 KEYGEN, 10 SIGN, 11 VERIFY, 00 illegal
//  cmd_msg       in   32   message for SIGN/VERIFY
//  cmd_s/P/R     in   len  signature s, public key P, commitment R (VERIFY only)
//  abort         in   1    cancel the running op
//  en_key/en_gen/en_ver out 1  datapath enables
//  msg_gen/msg_ver out 32  latched message to sign_gen / sign_ver
//  s_in/P_in/R_in  out len latched verify operands
//  valid_gen/valid_sign/valid_ver/done_ver in 1  datapath completion flags
//  s_out/P_out/R_out in len  datapath results
//  rsp_valid     out  1    one-cycle response strobe
//  rsp_status    out  2    00 OK, 01 NOKEY, 10 TIMEOUT, 11 ABORT/BADOP
//  rsp_verified  out  1    VERIFY result (valid_ver at done); 0 for other ops
//  rsp_s/P/R     out  len  latched results: P after KEYGEN, s/R after SIGN
//  key_ok        out  1    a KEYGEN has completed since reset
//  busy          out  1    state != IDLE
// BEHAVIOUR
//  Reset: state IDLE. All enables, rsp_valid, rsp_status, rsp_verified, key_ok and busy are 0.
//    Latched msg/operands/results are 0. cmd_ready is 1 from the first cycle after reset.
//    Reset mid-op drops the enables on the same edge. No response is issued.
//  States: IDLE, KEYGEN, SIGN, VERIFY.
//  Accept: cmd_valid & cmd_ready at edge T.
//    - The command is latched.
//    - The state moves to the op state.
//    - The matching en_* is high from T+1 and held until completion.
//    - Exactly one enable is high at any time.
//  Illegal op (00): no enable is driven. rsp_valid pulses at T+1 with status 11. Stays in IDLE.
//  SIGN with key_ok=0: rsp_valid at T+1 with status 01. No enable is driven.
//  Completion flag per state:
//    - KEYGEN: valid_gen. P_out is latched to rsp_P and key_ok is set.
//    - SIGN: valid_sign. s_out/R_out are latched.
//    - VERIFY: done_ver. valid_ver is latched to rsp_verified.
//    - Flags are sampled only while the matching enable is high. Flags in IDLE are ignored.
//  Completion seen at edge C:
//    - Enable is low from C+1.
//    - rsp_valid=1 with status 00 for cycle C+1 only.
//    - State is IDLE at C+1, so cmd_ready=1 in the same cycle.
//    - The enable stays low for at least one cycle between consecutive ops.
//  Timeout: a cycle counter clears on accept and increments each cycle in an op state.
//    When count == TIMEOUT_CYC-1 with no completion: enable drops, status 10, return to IDLE.
//  Abort in an op state: enable drops next cycle, status 11, IDLE. Abort in IDLE is ignored.
//  Priority in the same cycle: rst > completion > abort > timeout.
//  rsp_* data holds its last value until the next response. rsp_verified is cleared on every non-VERIFY response.
// CONFIGURATION
//  SCHNORR_SEQ_AUTOKEY_EN defined: SIGN with key_ok=0 first runs an internal KEYGEN.
//    - Sequence: en_key until valid_gen, one idle cycle, then en_gen.
//    - One response is issued at the end, status 00.
//    - Timeout applies per phase.
//  Undefined: SIGN with key_ok=0 returns status 01 immediately (as above).
// TESTING
//  - Reset, then KEYGEN. valid_gen 5 cycles later with P_out=0x1A2B.
//    Expect en_key high 5 cycles, rsp_valid 1 cycle, rsp_P=0x1A2B, key_ok=1, status 00.
//  - SIGN before any KEYGEN. Expect status 01 at T+1 and en_gen never high
//    (with AUTOKEY_EN: en_key, then en_gen, then status 00).
//  - VERIFY msg=0xDEADBEEF; done_ver with valid_ver=1, then repeat with valid_ver=0.
//    Expect rsp_verified 1 then 0; msg_ver=0xDEADBEEF while en_ver is high.
//  - KEYGEN with valid_gen never asserted, TIMEOUT_CYC=16.
//    Expect en_key high exactly 16 cycles, then status 10 and IDLE.
//  - Abort on cycle 3 of SIGN; also abort and valid_sign in the same cycle.
//    Expect status 11 for the first case and status 00 for the second.
//  - Back-to-back commands with cmd_valid held.
//    Expect accept in the response cycle, one low enable cycle between ops, op 00 giving status 11.

Source files
------------

// File: rtl/schnorr_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | schnorr_seq_ctrl: one-at-a-time KEYGEN/SIGN/VERIFY sequencer with timeout |
// | Option: SCHNORR_SEQ_AUTOKEY_EN (SIGN without key runs internal KEYGEN)    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module schnorr_seq_ctrl #(
  parameter int LEN         = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_op_i,
  input  logic [31:0]     cmd_msg_i,
  input  logic [LEN-1:0]  cmd_s_i,
  input  logic [LEN-1:0]  cmd_P_i,
  input  logic [LEN-1:0]  cmd_R_i,
  input  logic            abort_i,
  output logic            en_key_o,
  output logic            en_gen_o,
  output logic            en_ver_o,
  output logic [31:0]     msg_gen_o,
  output logic [31:0]     msg_ver_o,
  output logic [LEN-1:0]  s_in_o,
  output logic [LEN-1:0]  P_in_o,
  output logic [LEN-1:0]  R_in_o,
  input  logic            valid_gen_i,
  input  logic            valid_sign_i,
  input  logic            valid_ver_i,
  input  logic            done_ver_i,
  input  logic [LEN-1:0]  s_out_i,
  input  logic [LEN-1:0]  P_out_i,
  input  logic [LEN-1:0]  R_out_i,
  output logic            rsp_valid_o,
  output logic [1:0]      rsp_status_o,
  output logic            rsp_verified_o,
  output logic [LEN-1:0]  rsp_s_o,
  output logic [LEN-1:0]  rsp_P_o,
  output logic [LEN-1:0]  rsp_R_o,
  output logic            key_ok_o,
  output logic            busy_o
);

  localparam int          CW     = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] C_TMAX = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] OP_KEYGEN = 2'b01;
  localparam logic [1:0] OP_SIGN   = 2'b10;
  localparam logic [1:0] OP_VERIFY = 2'b11;

  localparam logic [1:0] RSP_OK    = 2'b00;
  localparam logic [1:0] RSP_NOKEY = 2'b01;
  localparam logic [1:0] RSP_TMO   = 2'b10;
  localparam logic [1:0] RSP_ABORT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYGEN = 3'd1,
    ST_SIGN   = 3'd2,
`ifdef SCHNORR_SEQ_AUTOKEY_EN
    ST_VERIFY = 3'd3,
    ST_AKEY   = 3'd4,
    ST_AKGAP  = 3'd5
`else
    ST_VERIFY = 3'd3
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           key_ok_q, key_ok_d;
  logic [31:0]    msg_gen_q, msg_gen_d;
  logic [31:0]    msg_ver_q, msg_ver_d;
  logic [LEN-1:0] s_in_q, s_in_d, P_in_q, P_in_d, R_in_q, R_in_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [1:0]     rsp_status_q, rsp_status_d;
  logic           rsp_verified_q, rsp_verified_d;
  logic [LEN-1:0] rsp_s_q, rsp_s_d, rsp_P_q, rsp_P_d, rsp_R_q, rsp_R_d;
  logic           done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      key_ok_q       <= 1'b0;
      msg_gen_q      <= '0;
      msg_ver_q      <= '0;
      s_in_q         <= '0;
      P_in_q         <= '0;
      R_in_q         <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_status_q   <= 2'b00;
      rsp_verified_q <= 1'b0;
      rsp_s_q        <= '0;
      rsp_P_q        <= '0;
      rsp_R_q        <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      key_ok_q       <= key_ok_d;
      msg_gen_q      <= msg_gen_d;
      msg_ver_q      <= msg_ver_d;
      s_in_q         <= s_in_d;
      P_in_q         <= P_in_d;
      R_in_q         <= R_in_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_status_q   <= rsp_status_d;
      rsp_verified_q <= rsp_verified_d;
      rsp_s_q        <= rsp_s_d;
      rsp_P_q        <= rsp_P_d;
      rsp_R_q        <= rsp_R_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CW'(1);
    key_ok_d       = key_ok_q;
    msg_gen_d      = msg_gen_q;
    msg_ver_d      = msg_ver_q;
    s_in_d         = s_in_q;
    P_in_d         = P_in_q;
    R_in_d         = R_in_q;
    rsp_valid_d    = 1'b0;
    rsp_status_d   = rsp_status_q;
    rsp_verified_d = rsp_verified_q;
    rsp_s_d        = rsp_s_q;
    rsp_P_d        = rsp_P_q;
    rsp_R_d        = rsp_R_q;

    // Completion flags only count while the matching enable is driven.
    case (state_q)
      ST_KEYGEN: done = valid_gen_i;
      ST_SIGN:   done = valid_sign_i;
      ST_VERIFY: done = done_ver_i;
      default:   done = 1'b0;
    endcase

    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (cmd_valid_i) begin
        case (cmd_op_i)
          OP_KEYGEN: state_d = ST_KEYGEN;
          OP_SIGN: begin
            msg_gen_d = cmd_msg_i;
            if (key_ok_q) begin
              state_d = ST_SIGN;
            end else begin
`ifdef SCHNORR_SEQ_AUTOKEY_EN
              state_d = ST_AKEY;
`else
              rsp_valid_d    = 1'b1;
              rsp_status_d   = RSP_NOKEY;
              rsp_verified_d = 1'b0;
`endif
            end
          end
          OP_VERIFY: begin
            state_d   = ST_VERIFY;
            msg_ver_d = cmd_msg_i;
            s_in_d    = cmd_s_i;
            P_in_d    = cmd_P_i;
            R_in_d    = cmd_R_i;
          end
          default: begin
            rsp_valid_d    = 1'b1;
            rsp_status_d   = RSP_ABORT;
            rsp_verified_d = 1'b0;
          end
        endcase
      end
    end
`ifdef SCHNORR_SEQ_AUTOKEY_EN
    else if (state_q == ST_AKEY && valid_gen_i) begin
      // Key is usable from here on; the single response comes after SIGN.
      key_ok_d = 1'b1;
      state_d  = ST_AKGAP;
      cnt_d    = '0;
    end
    else if (state_q == ST_AKGAP) begin
      cnt_d = '0;
      if (abort_i) begin
        state_d        = ST_IDLE;
        rsp_valid_d    = 1'b1;
        rsp_status_d   = RSP_ABORT;
        rsp_verified_d = 1'b0;
      end else begin
        state_d = ST_SIGN;
      end
    end
`endif
    else if (done) begin
      state_d        = ST_IDLE;
      rsp_valid_d    = 1'b1;
      rsp_status_d   = RSP_OK;
      rsp_verified_d = 1'b0;
      case (state_q)
        ST_KEYGEN: begin
          rsp_P_d  = P_out_i;
          key_ok_d = 1'b1;
        end
        ST_SIGN: begin
          rsp_s_d = s_out_i;
          rsp_R_d = R_out_i;
        end
        ST_VERIFY: rsp_verified_d = valid_ver_i;
        default: ;
      endcase
    end else if (abort_i) begin
      state_d        = ST_IDLE;
      rsp_valid_d    = 1'b1;
      rsp_status_d   = RSP_ABORT;
      rsp_verified_d = 1'b0;
    end else if (cnt_q == C_TMAX) begin
      state_d        = ST_IDLE;
      rsp_valid_d    = 1'b1;
      rsp_status_d   = RSP_TMO;
      rsp_verified_d = 1'b0;
    end
  end

`ifdef SCHNORR_SEQ_AUTOKEY_EN
  assign en_key_o = (state_q == ST_KEYGEN) || (state_q == ST_AKEY);
`else
  assign en_key_o = (state_q == ST_KEYGEN);
`endif
  assign en_gen_o       = (state_q == ST_SIGN);
  assign en_ver_o       = (state_q == ST_VERIFY);
  assign cmd_ready_o    = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign key_ok_o       = key_ok_q;
  assign msg_gen_o      = msg_gen_q;
  assign msg_ver_o      = msg_ver_q;
  assign s_in_o         = s_in_q;
  assign P_in_o         = P_in_q;
  assign R_in_o         = R_in_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_status_o   = rsp_status_q;
  assign rsp_verified_o = rsp_verified_q;
  assign rsp_s_o        = rsp_s_q;
  assign rsp_P_o        = rsp_P_q;
  assign rsp_R_o        = rsp_R_q;

endmodule
`default_nettype wire

// File: tb/tb_schnorr_seq_ctrl.sv
`default_nettype none
// Directed bench for schnorr_seq_ctrl; responses are checked against a queue of expectations.
module tb_schnorr_seq_ctrl;
  localparam int LEN = 16;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [31:0] cmd_msg = '0;
  logic [LEN-1:0] cmd_s = '0, cmd_P = '0, cmd_R = '0;
  logic abort = 1'b0;
  logic en_key, en_gen, en_ver;
  logic [31:0] msg_gen, msg_ver;
  logic [LEN-1:0] s_in, P_in, R_in;
  logic valid_gen = 1'b0, valid_sign = 1'b0, valid_ver = 1'b0, done_ver = 1'b0;
  logic [LEN-1:0] s_out = '0, P_out = '0, R_out = '0;
  logic rsp_valid, rsp_verified, key_ok, busy;
  logic [1:0] rsp_status;
  logic [LEN-1:0] rsp_s, rsp_P, rsp_R;

  always #5 clk = ~clk;

  schnorr_seq_ctrl #(.LEN(LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_msg_i(cmd_msg),
    .cmd_s_i(cmd_s), .cmd_P_i(cmd_P), .cmd_R_i(cmd_R), .abort_i(abort),
    .en_key_o(en_key), .en_gen_o(en_gen), .en_ver_o(en_ver),
    .msg_gen_o(msg_gen), .msg_ver_o(msg_ver), .s_in_o(s_in), .P_in_o(P_in), .R_in_o(R_in),
    .valid_gen_i(valid_gen), .valid_sign_i(valid_sign), .valid_ver_i(valid_ver), .done_ver_i(done_ver),
    .s_out_i(s_out), .P_out_i(P_out), .R_out_i(R_out),
    .rsp_valid_o(rsp_valid), .rsp_status_o(rsp_status), .rsp_verified_o(rsp_verified),
    .rsp_s_o(rsp_s), .rsp_P_o(rsp_P), .rsp_R_o(rsp_R),
    .key_ok_o(key_ok), .busy_o(busy)
  );

  typedef struct packed {
    logic [1:0]     st;
    logic           ver;
    logic [LEN-1:0] s;
    logic [LEN-1:0] p;
    logic [LEN-1:0] r;
  } rsp_t;

  rsp_t sb[$];
  rsp_t e;
  int checks = 0;
  int errors = 0;
  int key_cyc = 0, gen_cyc = 0, ver_cyc = 0;
  int k0, g0;
  logic [LEN-1:0] m_s = '0, m_p = '0, m_r = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] st, input logic ver);
    sb.push_back('{st: st, ver: ver, s: m_s, p: m_p, r: m_r});
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] msg);
    for (int i = 0; i < 40 && !cmd_ready; i++) tick();
    chk("cmd_ready_before_send", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_msg   = msg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    chk({"drain_", tag}, sb.size(), 32'd0);
  endtask

  // Response scoreboard and per-cycle enable bookkeeping.
  always @(negedge clk) begin
    if (!rst) begin
      chk("en_onehot", {31'b0, $onehot0({en_key, en_gen, en_ver})}, 32'd1);
      key_cyc += int'(en_key);
      gen_cyc += int'(en_gen);
      ver_cyc += int'(en_ver);
      if (rsp_valid) begin
        chk("rsp_expected", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_status", {30'b0, rsp_status}, {30'b0, e.st});
          chk("rsp_verified", {31'b0, rsp_verified}, {31'b0, e.ver});
          chk("rsp_s", {16'b0, rsp_s}, {16'b0, e.s});
          chk("rsp_P", {16'b0, rsp_P}, {16'b0, e.p});
          chk("rsp_R", {16'b0, rsp_R}, {16'b0, e.r});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_en", {29'b0, en_key, en_gen, en_ver}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_status", {30'b0, rsp_status}, 32'd0);
    chk("rst_key_ok", {30'b0, key_ok, busy}, 32'd0);
    chk("rst_rsp_P", {16'b0, rsp_P}, 32'd0);
    chk("rst_msg_gen", msg_gen, 32'd0);
    rst = 1'b0;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    tick();

    // SIGN without a key
    g0 = gen_cyc;
    push(2'b01, 1'b0);
    send(2'b10, 32'hCAFE0001);
    chk("nokey_en_gen", {31'b0, en_gen}, 32'd0);
    chk("nokey_busy", {31'b0, busy}, 32'd0);
    drain("nokey");
    repeat (3) tick();
    chk("nokey_gen_cycles", gen_cyc - g0, 32'd0);

    // KEYGEN, completes after 5 enabled cycles
    k0 = key_cyc;
    m_p = 16'h1A2B;
    push(2'b00, 1'b0);
    send(2'b01, 32'h0);
    repeat (4) begin
      chk("kg_en_key", {31'b0, en_key}, 32'd1);
      tick();
    end
    valid_gen = 1'b1;
    P_out = 16'h1A2B;
    tick();
    valid_gen = 1'b0;
    P_out = '0;
    chk("kg_en_key_low", {31'b0, en_key}, 32'd0);
    chk("kg_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("kg_key_ok", {31'b0, key_ok}, 32'd1);
    drain("keygen");
    chk("kg_en_cycles", key_cyc - k0, 32'd5);

    // SIGN with a key
    m_s = 16'h5555;
    m_r = 16'h7777;
    push(2'b00, 1'b0);
    send(2'b10, 32'h12345678);
    chk("sign_msg_gen", msg_gen, 32'h12345678);
    chk("sign_en_gen", {31'b0, en_gen}, 32'd1);
    tick();
    tick();
    valid_sign = 1'b1;
    s_out = 16'h5555;
    R_out = 16'h7777;
    tick();
    valid_sign = 1'b0;
    drain("sign");

    // VERIFY passing, then failing
    cmd_s = 16'h0101;
    cmd_P = 16'h0202;
    cmd_R = 16'h0303;
    push(2'b00, 1'b1);
    send(2'b11, 32'hDEADBEEF);
    chk("ver_msg", msg_ver, 32'hDEADBEEF);
    chk("ver_en", {31'b0, en_ver}, 32'd1);
    chk("ver_ops", {P_in, R_in}, {16'h0202, 16'h0303});
    chk("ver_s_in", {16'b0, s_in}, 32'h0101);
    tick();
    chk("ver_msg_hold", msg_ver, 32'hDEADBEEF);
    done_ver = 1'b1;
    valid_ver = 1'b1;
    tick();
    done_ver = 1'b0;
    valid_ver = 1'b0;
    drain("verify_pass");
    chk("ver_rsp_hold", {31'b0, rsp_verified}, 32'd1);
    push(2'b00, 1'b0);
    send(2'b11, 32'hDEADBEEF);
    tick();
    done_ver = 1'b1;
    tick();
    done_ver = 1'b0;
    drain("verify_fail");

    // KEYGEN that never completes
    k0 = key_cyc;
    push(2'b10, 1'b0);
    send(2'b01, 32'h0);
    drain("timeout");
    chk("tmo_en_cycles", key_cyc - k0, TMO);
    chk("tmo_busy", {31'b0, busy}, 32'd0);
    chk("tmo_key_ok", {31'b0, key_ok}, 32'd1);

    // Abort on cycle 3 of SIGN
    g0 = gen_cyc;
    push(2'b11, 1'b0);
    send(2'b10, 32'h0000AAAA);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_en_gen", {31'b0, en_gen}, 32'd0);
    drain("abort");
    chk("abort_gen_cycles", gen_cyc - g0, 32'd3);

    // Abort and completion together: completion wins
    m_s = 16'h0BAD;
    m_r = 16'h0CAD;
    push(2'b00, 1'b0);
    send(2'b10, 32'h0000BBBB);
    tick();
    abort = 1'b1;
    valid_sign = 1'b1;
    s_out = 16'h0BAD;
    R_out = 16'h0CAD;
    tick();
    abort = 1'b0;
    valid_sign = 1'b0;
    drain("abort_vs_done");

    // Abort in IDLE has no effect
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", {31'b0, busy}, 32'd0);
    tick();

    // Back-to-back with cmd_valid held: KEYGEN, VERIFY, illegal op
    m_p = 16'h2222;
    push(2'b00, 1'b0);
    push(2'b00, 1'b1);
    push(2'b11, 1'b0);
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    tick();
    chk("b2b_en_key", {31'b0, en_key}, 32'd1);
    cmd_op = 2'b11;
    cmd_msg = 32'hB2B2B2B2;
    valid_gen = 1'b1;
    P_out = 16'h2222;
    tick();
    valid_gen = 1'b0;
    chk("b2b_gap_en", {29'b0, en_key, en_gen, en_ver}, 32'd0);
    chk("b2b_gap_ready", {31'b0, cmd_ready}, 32'd1);
    tick();
    chk("b2b_en_ver", {31'b0, en_ver}, 32'd1);
    chk("b2b_msg_ver", msg_ver, 32'hB2B2B2B2);
    cmd_op = 2'b00;
    done_ver = 1'b1;
    valid_ver = 1'b1;
    tick();
    done_ver = 1'b0;
    valid_ver = 1'b0;
    chk("b2b_gap2_en", {29'b0, en_key, en_gen, en_ver}, 32'd0);
    chk("b2b_gap2_ready", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_badop_busy", {31'b0, busy}, 32'd0);
    drain("b2b");
    repeat (3) tick();
    chk("final_queue", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
